free_list_bitmap_mp: RTL and testbench
======================================

# free_list_bitmap_mp

Multi-port physical-register free list for the out-of-order core: ALLOC_W rename lanes allocate and FREE_W commit lanes release physical registers each cycle. Sits between rename (allocation) and ROB commit (release), with N_CKPT branch checkpoints for misprediction recovery. Unlike the single-port free list, committed frees are broadcast into every live checkpoint, so a later recovery never leaks registers. Frees that arrive in the same cycle as a recovery are also kept.

## Interface
- N_ARCH_REGS, 32, architectural regs; pregs 0..N_ARCH_REGS-1 reserved at reset
- N_PHYS_REGS, 64, physical register count
- PREG_W, 6, preg index width
- ALLOC_W, 2, rename allocation lanes
- FREE_W, 2, commit free lanes
- N_CKPT, 8, checkpoint slots
- CKPT_W, 3, checkpoint tag width
- CNT_W, 7, free-count width = $clog2(N_PHYS_REGS+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- recover_i  in  1  restore from checkpoint this cycle
- recover_tag_i  in  CKPT_W  checkpoint slot to restore
- alloc_req_i  in  ALLOC_W  per-lane request; must be a thermometer prefix from lane 0
- alloc_gnt_o  out  1  all requested lanes granted (all-or-nothing)
- alloc_preg_o  out  ALLOC_W×PREG_W  lane i = i-th lowest free preg ≥ N_ARCH_REGS, else 0
- free_valid_i  in  FREE_W  per-lane free strobe
- free_preg_i  in  FREE_W×PREG_W  preg to release
- ckpt_take_i  in  1  snapshot post-update map
- ckpt_tag_i  in  CKPT_W  slot to write
- free_count_o  out  CNT_W  popcount of current map
- free_bitmap_o  out  N_PHYS_REGS  current map, 1 = free

## Operation
- State: free_map[N_PHYS_REGS] and ckpt_map[N_CKPT][N_PHYS_REGS].
- Pick: combinational. alloc_preg_o[i] is the (i+1)-th lowest set bit of free_map in [N_ARCH_REGS, N_PHYS_REGS). If fewer than i+1 bits are set, the lane outputs 0.
- Grant: alloc_gnt_o = |alloc_req_i & !recover_i & (popcount(alloc_req_i) ≤ free_count_o).
  - On grant, every requested lane's preg clears at the edge.
  - There is no partial grant.
- Free: each valid lane with preg ≠ 0 sets that bit in free_map. It also sets the same bit in every ckpt_map slot, because a committed free is older than every live checkpoint.
  - preg 0 is ignored.
  - Pregs 1..N_ARCH_REGS-1 are legal; they are released after rename.
- Same cycle, normal update: next = (free_map | frees) & ~grants. Allocation picks only from the current free_map; same-cycle frees are not visible to it.
- Checkpoint: when ckpt_take_i is high and recover_i is low, ckpt_map[ckpt_tag_i] ← next. If the written slot's other update is a same-cycle free broadcast, the snapshot wins; the snapshot already contains that free.
- Recovery: free_map ← ckpt_map[recover_tag_i] | frees.
  - Grant is forced to 0.
  - ckpt_take_i is ignored.
  - The free broadcast to checkpoints still applies.
- Illegal inputs (SVA, no defined behaviour required):
  - non-prefix alloc_req_i
  - freeing an already-free preg
  - two free lanes naming the same nonzero preg
  - recover_tag_i naming a slot never written since reset

## Timing
- Reset (async assert):
  - free_map = bits N_ARCH_REGS..N_PHYS_REGS-1 set; all ckpt_map = 0
  - free_count_o = 32; alloc_gnt_o = 0; alloc_preg_o = {32, 33} (lane 0 = 32, lane 1 = 33)
- Reset deassertion must be synchronised externally. The first update happens on the first edge with rst low.
- Grant and preg outputs are combinational from registered state plus inputs. There are no input-to-state combinational loops.
- Frees and allocations become visible in free_bitmap_o, free_count_o and alloc_preg_o one cycle after the edge.
- Recovery has 1-cycle latency; allocation can resume in the cycle after recover_i.
- Full condition: free_count_o = 0 makes alloc_gnt_o 0 for any request.
- Near-full: if free_count_o = 1 and alloc_req_i = 2'b11, there is no grant. If alloc_req_i = 2'b01, lane 0 is granted.

## Structure
- ooop_types package provides the defaults N_ARCH_REGS, N_PHYS_REGS, PREG_W and adds N_CKPT, CKPT_W, ALLOC_W, FREE_W.
- Sub-module preg_pick_n: a parametrised N-lowest-set-bit picker (ALLOC_W outputs plus per-output valid) over a masked bitmap. It is reused by the future wider-issue rename stage.
- The top level holds state, free broadcast, checkpoint write, recovery mux and popcount.

## Test plan
- Reset, then alloc_req=11 for 16 cycles → grants 32/33, 34/35 … 62/63. free_count_o goes 32→0, then grant drops.
- free_count_o=1, alloc_req=11 → gnt=0 and map unchanged; alloc_req=01 → gnt=1 and the last preg clears.
- Same cycle: free preg 40 while allocating with map lowest free=41 → alloc gets 41 (not 40); next cycle preg 40 is the lowest free.
- ckpt_take tag 3 after allocating 32,33; allocate 34,35; commit-free 33; recover tag 3 → 34,35 free again AND 33 free. free_count_o is 32 minus 1 (preg 32 still allocated).
- recover_i with simultaneous free of 50 and alloc_req=11 → gnt=0; map = ckpt | bit50; ckpt_take ignored that cycle.
- Assert rst mid-burst → outputs return to reset values immediately; checkpoints read back zero.

Source files
------------

// File: rtl/ooop_types.sv
// ooop_types: shared sizing for the out-of-order core's rename and free-list blocks
package ooop_types;
  localparam int N_ARCH_REGS = 32;
  localparam int N_PHYS_REGS = 64;
  localparam int PREG_W = 6;
  localparam int ALLOC_W = 2;
  localparam int FREE_W = 2;
  localparam int N_CKPT = 8;
  localparam int CKPT_W = 3;
  localparam int CNT_W = $clog2(N_PHYS_REGS + 1);
  localparam logic [N_PHYS_REGS-1:0] RENAME_MASK = {{(N_PHYS_REGS-N_ARCH_REGS){1'b1}}, {N_ARCH_REGS{1'b0}}};
endpackage

// File: rtl/preg_pick_n.sv
// preg_pick_n: picks the K lowest set bits of (map & mask), lowest first; unused outputs read 0
module preg_pick_n #(
  parameter int N = 64,
  parameter int W = 6,
  parameter int K = 2
) (
  input  logic [N-1:0]   map,
  input  logic [N-1:0]   mask,
  output logic [K*W-1:0] idx,
  output logic [K-1:0]   vld
);
  always_comb begin
    int n;
    idx = '0;
    vld = '0;
    n = 0;
    for (int b = 0; b < N; b++)
      if (map[b] && mask[b] && n < K) begin
        idx[n*W +: W] = W'(b);
        vld[n] = 1'b1;
        n = n + 1;
      end
  end
endmodule

// File: rtl/free_list_bitmap_mp.sv
// free_list_bitmap_mp: multi-port physical register free list with checkpoints that also absorb committed frees
module free_list_bitmap_mp
  import ooop_types::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      recover_i,
  input  logic [CKPT_W-1:0]         recover_tag_i,
  input  logic [ALLOC_W-1:0]        alloc_req_i,
  output logic                      alloc_gnt_o,
  output logic [ALLOC_W*PREG_W-1:0] alloc_preg_o,
  input  logic [FREE_W-1:0]         free_valid_i,
  input  logic [FREE_W*PREG_W-1:0]  free_preg_i,
  input  logic                      ckpt_take_i,
  input  logic [CKPT_W-1:0]         ckpt_tag_i,
  output logic [CNT_W-1:0]          free_count_o,
  output logic [N_PHYS_REGS-1:0]    free_bitmap_o
);
  logic [N_PHYS_REGS-1:0] free_map, frees, grants, nxt;
  logic [N_PHYS_REGS-1:0] ckpt_map [N_CKPT];
  logic [N_CKPT-1:0] ckpt_wr;
  logic [ALLOC_W-1:0] pick_vld;
  preg_pick_n #(.N(N_PHYS_REGS), .W(PREG_W), .K(ALLOC_W)) u_pick (
    .map(free_map),
    .mask(RENAME_MASK),
    .idx(alloc_preg_o),
    .vld(pick_vld)
  );
  assign free_bitmap_o = free_map;
  assign free_count_o = CNT_W'($countones(free_map));
  assign alloc_gnt_o = |alloc_req_i && !recover_i && CNT_W'($countones(alloc_req_i)) <= free_count_o;
  always_comb begin
    frees = '0;
    grants = '0;
    for (int i = 0; i < FREE_W; i++)
      if (free_valid_i[i] && free_preg_i[i*PREG_W +: PREG_W] != '0) frees[free_preg_i[i*PREG_W +: PREG_W]] = 1'b1;
    for (int i = 0; i < ALLOC_W; i++)
      if (alloc_gnt_o && alloc_req_i[i] && pick_vld[i]) grants[alloc_preg_o[i*PREG_W +: PREG_W]] = 1'b1;
    nxt = (free_map | frees) & ~grants;
  end
  // a snapshot already contains this cycle's frees, so it simply overrides the broadcast
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      free_map <= RENAME_MASK;
      ckpt_wr <= '0;
      for (int c = 0; c < N_CKPT; c++) ckpt_map[c] <= '0;
    end else begin
      free_map <= recover_i ? ckpt_map[recover_tag_i] | frees : nxt;
      for (int c = 0; c < N_CKPT; c++)
        if (ckpt_take_i && !recover_i && ckpt_tag_i == CKPT_W'(c)) begin
          ckpt_map[c] <= nxt;
          ckpt_wr[c] <= 1'b1;
        end else ckpt_map[c] <= ckpt_map[c] | frees;
    end
  a_prefix: assert property (@(posedge clk) disable iff (rst) (alloc_req_i & (alloc_req_i + ALLOC_W'(1))) == '0);
  a_tag: assert property (@(posedge clk) disable iff (rst) recover_i |-> ckpt_wr[recover_tag_i]);
  for (genvar i = 0; i < FREE_W; i++) begin : g_free
    a_dbl: assert property (@(posedge clk) disable iff (rst)
      free_valid_i[i] && free_preg_i[i*PREG_W +: PREG_W] != '0 |-> !free_map[free_preg_i[i*PREG_W +: PREG_W]]);
    for (genvar j = i + 1; j < FREE_W; j++) begin : g_pair
      a_dup: assert property (@(posedge clk) disable iff (rst)
        !(free_valid_i[i] && free_valid_i[j] && free_preg_i[i*PREG_W +: PREG_W] != '0 &&
          free_preg_i[i*PREG_W +: PREG_W] == free_preg_i[j*PREG_W +: PREG_W]));
    end
  end
endmodule

// File: tb/tb_free_list_bitmap_mp.sv
// tb_free_list_bitmap_mp: vector table, corner sequences and randomized traffic against a set-based model
module tb_free_list_bitmap_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic recover_i, ckpt_take_i, alloc_gnt_o;
  logic [2:0] recover_tag_i, ckpt_tag_i;
  logic [1:0] alloc_req_i, free_valid_i;
  logic [11:0] alloc_preg_o, free_preg_i;
  logic [6:0] free_count_o;
  logic [63:0] free_bitmap_o;
  always #5 clk = ~clk;
  free_list_bitmap_mp dut (
    .clk(clk), .rst(rst), .recover_i(recover_i), .recover_tag_i(recover_tag_i),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_preg_o(alloc_preg_o),
    .free_valid_i(free_valid_i), .free_preg_i(free_preg_i), .ckpt_take_i(ckpt_take_i),
    .ckpt_tag_i(ckpt_tag_i), .free_count_o(free_count_o), .free_bitmap_o(free_bitmap_o)
  );
  typedef struct {
    logic rec; logic [2:0] rtag; logic [1:0] req; logic [1:0] fv; logic [5:0] f0, f1;
    logic take; logic [2:0] ttag; logic gnt; logic [5:0] p0, p1; logic [6:0] cnt;
  } vec_t;
  int tests = 0, fails = 0;
  bit mfree [64];
  bit mck [8][64];
  bit mwritten [8];
  vec_t tv [22];
  function automatic vec_t mk(int rec, int rtag, int req, int fv, int f0, int f1, int take, int ttag,
                              int gnt, int p0, int p1, int cnt);
    vec_t v;
    v.rec = rec[0]; v.rtag = rtag[2:0]; v.req = req[1:0]; v.fv = fv[1:0]; v.f0 = f0[5:0]; v.f1 = f1[5:0];
    v.take = take[0]; v.ttag = ttag[2:0]; v.gnt = gnt[0]; v.p0 = p0[5:0]; v.p1 = p1[5:0]; v.cnt = cnt[6:0];
    return v;
  endfunction
  function automatic int mcount();
    int n = 0;
    for (int b = 0; b < 64; b++) n += int'(mfree[b]);
    return n;
  endfunction
  function automatic int mpick(int k);
    int n = 0;
    for (int b = 32; b < 64; b++)
      if (mfree[b]) begin
        if (n == k) return b;
        n++;
      end
    return 0;
  endfunction
  function automatic logic [63:0] mmap();
    logic [63:0] m;
    for (int b = 0; b < 64; b++) m[b] = mfree[b];
    return m;
  endfunction
  task automatic model_reset();
    for (int b = 0; b < 64; b++) begin
      mfree[b] = (b >= 32);
      for (int c = 0; c < 8; c++) mck[c][b] = 1'b0;
    end
    for (int c = 0; c < 8; c++) mwritten[c] = 1'b0;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    recover_i = v.rec; recover_tag_i = v.rtag; alloc_req_i = v.req; free_valid_i = v.fv;
    free_preg_i = {v.f1, v.f0}; ckpt_take_i = v.take; ckpt_tag_i = v.ttag;
  endtask
  task automatic chk_reset_vals();
    chk("rst_gnt", 64'(alloc_gnt_o), 0);
    chk("rst_count", 64'(free_count_o), 32);
    chk("rst_preg", 64'(alloc_preg_o), 64'({6'd33, 6'd32}));
    chk("rst_bitmap", free_bitmap_o, 64'hFFFF_FFFF_0000_0000);
  endtask
  // starts and ends on a falling edge; model advances on the rising edge
  task automatic step(input vec_t v, input bit tab);
    bit e_gnt, fr [64];
    int p0, p1;
    drive(v);
    #1;
    p0 = mpick(0);
    p1 = mpick(1);
    e_gnt = (v.req != 0) && !v.rec && (int'(v.req[0]) + int'(v.req[1]) <= mcount());
    chk("gnt", 64'(alloc_gnt_o), 64'(e_gnt));
    chk("preg0", 64'(alloc_preg_o[5:0]), 64'(p0));
    chk("preg1", 64'(alloc_preg_o[11:6]), 64'(p1));
    chk("count", 64'(free_count_o), 64'(mcount()));
    chk("bitmap", free_bitmap_o, mmap());
    if (tab) begin
      chk("tab_gnt", 64'(alloc_gnt_o), 64'(v.gnt));
      chk("tab_preg0", 64'(alloc_preg_o[5:0]), 64'(v.p0));
      chk("tab_preg1", 64'(alloc_preg_o[11:6]), 64'(v.p1));
      chk("tab_count", 64'(free_count_o), 64'(v.cnt));
    end
    @(posedge clk);
    for (int b = 0; b < 64; b++) fr[b] = 1'b0;
    if (v.fv[0] && v.f0 != 0) fr[v.f0] = 1'b1;
    if (v.fv[1] && v.f1 != 0) fr[v.f1] = 1'b1;
    if (v.rec) mfree = mck[v.rtag];
    else if (e_gnt) begin
      if (v.req[0]) mfree[p0] = 1'b0;
      if (v.req[1]) mfree[p1] = 1'b0;
    end
    for (int b = 0; b < 64; b++)
      if (fr[b]) begin
        mfree[b] = 1'b1;
        for (int c = 0; c < 8; c++) mck[c][b] = 1'b1;
      end
    if (!v.rec && v.take) begin
      mck[v.ttag] = mfree;
      mwritten[v.ttag] = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    vec_t v;
    for (int k = 0; k < 16; k++) tv[k] = mk(0,0,3,0,0,0,0,0, 1, 32+2*k, 33+2*k, 32-2*k);
    tv[16] = mk(0,0,3,0,0,0,0,0, 0,0,0,0);
    tv[17] = mk(0,0,3,3,40,41,0,0, 0,0,0,0);
    tv[18] = mk(0,0,1,0,0,0,0,0, 1,40,41,2);
    tv[19] = mk(0,0,3,0,0,0,0,0, 0,41,0,1);
    tv[20] = mk(0,0,1,0,0,0,0,0, 1,41,0,1);
    tv[21] = mk(0,0,0,0,0,0,0,0, 0,0,0,0);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    model_reset();
    #7 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) step(tv[i], 1);
    // same-cycle free is invisible to the picker
    do_reset();
    repeat (4) step(mk(0,0,3,0,0,0,0,0,0,0,0,0), 0);
    step(mk(0,0,1,0,0,0,0,0,0,0,0,0), 0);
    step(mk(0,0,1,1,40,0,0,0, 1,41,42,23), 1);
    step(mk(0,0,0,0,0,0,0,0, 0,40,42,23), 1);
    // checkpoint absorbs a later committed free
    do_reset();
    step(mk(0,0,3,0,0,0,1,3, 1,32,33,32), 1);
    step(mk(0,0,3,0,0,0,0,0, 1,34,35,30), 1);
    step(mk(0,0,0,1,33,0,0,0, 0,36,37,28), 1);
    step(mk(1,3,0,0,0,0,0,0, 0,33,36,29), 1);
    step(mk(0,0,0,0,0,0,0,0, 0,33,34,31), 1);
    repeat (9) step(mk(0,0,3,0,0,0,0,0,0,0,0,0), 0);
    step(mk(1,3,3,1,50,0,1,3, 0,51,52,13), 1);
    step(mk(0,0,0,0,0,0,0,0, 0,33,34,31), 1);
    repeat (2) step(mk(0,0,3,0,0,0,0,0,0,0,0,0), 0);
    step(mk(1,3,0,0,0,0,0,0,0,0,0,0), 0);
    step(mk(0,0,0,0,0,0,0,0, 0,33,34,31), 1);
    // reset in the middle of an allocation burst
    do_reset();
    repeat (3) step(mk(0,0,3,0,0,0,0,0,0,0,0,0), 0);
    do_reset();
    step(mk(0,0,0,0,0,0,0,0, 0,32,33,32), 1);
    for (int n = 0; n < 400; n++) begin
      int r, base;
      v = mk(0,0,0,0,0,0,0,0,0,0,0,0);
      r = $urandom_range(0, 2);
      v.req = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      if ($urandom_range(0, 11) == 0) begin
        base = $urandom_range(0, 7);
        for (int t = 0; t < 8; t++)
          if (!v.rec && mwritten[(base + t) % 8]) begin
            v.rec = 1'b1;
            v.rtag = 3'((base + t) % 8);
          end
      end
      for (int l = 0; l < 2; l++)
        if ($urandom_range(0, 1) == 1)
          for (int a = 0; a < 8; a++) begin
            int c = $urandom_range(32, 63);
            if (!v.fv[l] && !mfree[c] && !(l == 1 && v.fv[0] && int'(v.f0) == c)) begin
              v.fv[l] = 1'b1;
              if (l == 0) v.f0 = 6'(c);
              else v.f1 = 6'(c);
            end
          end
      v.take = ($urandom_range(0, 3) == 0);
      v.ttag = 3'($urandom_range(0, 7));
      step(v, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
